// File: rtl/fast_subtractor_pipe_if.sv
// Valid/ready operand and result bundle for fast_subtractor_pipe.
// The slave modport is the subtractor's view; the master modport is the source/sink side.
interface fast_subtractor_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_diff;
   logic             out_borrow;
   logic             out_overflow;

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_diff, out_borrow, out_overflow
   );

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid, out_diff, out_borrow, out_overflow
   );
endinterface

// File: rtl/fast_subtractor_pipe.sv
// Three-stage pipelined subtractor (a + ~b + 1), split into lower/upper half lookahead
// stages, with borrow and signed-overflow flags and a bubble-free valid/ready chain.
module fast_subtractor_pipe #(
   parameter int unsigned WIDTH = 32
) (
   input logic                   clock,
   input logic                   reset,
   fast_subtractor_pipe_if.slave bus
);
   localparam int unsigned HALF = WIDTH / 2;

   logic             v1_q, v1_d;
   logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;

   logic             v2_q, v2_d;
   logic [HALF-1:0]  lo2_q, lo2_d;
   logic             c2_q, c2_d;
   logic [HALF-1:0]  ahi2_q, ahi2_d, bhi2_q, bhi2_d;

   logic             v3_q, v3_d;
   logic [WIDTH-1:0] diff3_q, diff3_d;
   logic             brw3_q, brw3_d;
   logic             ovf3_q, ovf3_d;

   logic             rdy1, rdy2, rdy3;
   logic [HALF:0]    lo_sum, hi_sum;

   always_comb begin
      rdy3 = !v3_q | bus.out_ready;
      rdy2 = !v2_q | rdy3;
      rdy1 = !v1_q | rdy2;

      // Carry-in of 1 on the lower half completes the two's-complement negation of b.
      lo_sum = {1'b0, a1_q[HALF-1:0]} + {1'b0, ~b1_q[HALF-1:0]} + {{HALF{1'b0}}, 1'b1};
      hi_sum = {1'b0, ahi2_q} + {1'b0, ~bhi2_q} + {{HALF{1'b0}}, c2_q};

      v1_d    = v1_q;
      a1_d    = a1_q;
      b1_d    = b1_q;
      v2_d    = v2_q;
      lo2_d   = lo2_q;
      c2_d    = c2_q;
      ahi2_d  = ahi2_q;
      bhi2_d  = bhi2_q;
      v3_d    = v3_q;
      diff3_d = diff3_q;
      brw3_d  = brw3_q;
      ovf3_d  = ovf3_q;

      if (rdy1) begin
         v1_d = bus.in_valid;
         a1_d = bus.in_a;
         b1_d = bus.in_b;
      end

      if (rdy2) begin
         v2_d   = v1_q;
         lo2_d  = lo_sum[HALF-1:0];
         c2_d   = lo_sum[HALF];
         ahi2_d = a1_q[WIDTH-1:HALF];
         bhi2_d = b1_q[WIDTH-1:HALF];
      end

      if (rdy3) begin
         v3_d    = v2_q;
         diff3_d = {hi_sum[HALF-1:0], lo2_q};
         brw3_d  = !hi_sum[HALF];
         ovf3_d  = (ahi2_q[HALF-1] ^ bhi2_q[HALF-1]) & (hi_sum[HALF-1] ^ ahi2_q[HALF-1]);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         v1_q    <= 1'b0;
         a1_q    <= '0;
         b1_q    <= '0;
         v2_q    <= 1'b0;
         lo2_q   <= '0;
         c2_q    <= 1'b0;
         ahi2_q  <= '0;
         bhi2_q  <= '0;
         v3_q    <= 1'b0;
         diff3_q <= '0;
         brw3_q  <= 1'b0;
         ovf3_q  <= 1'b0;
      end else begin
         v1_q    <= v1_d;
         a1_q    <= a1_d;
         b1_q    <= b1_d;
         v2_q    <= v2_d;
         lo2_q   <= lo2_d;
         c2_q    <= c2_d;
         ahi2_q  <= ahi2_d;
         bhi2_q  <= bhi2_d;
         v3_q    <= v3_d;
         diff3_q <= diff3_d;
         brw3_q  <= brw3_d;
         ovf3_q  <= ovf3_d;
      end
   end

   assign bus.in_ready     = rdy1;
   assign bus.out_valid    = v3_q;
   assign bus.out_diff     = diff3_q;
   assign bus.out_borrow   = brw3_q;
   assign bus.out_overflow = ovf3_q;
endmodule

// File: tb/tb_fast_subtractor_pipe.sv
// Directed-vector bench for fast_subtractor_pipe: single-op table, streaming scoreboard,
// backpressure hold and mid-flight asynchronous reset.
module tb_fast_subtractor_pipe;
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] diff;
      logic        brw;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
   } op_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fast_subtractor_pipe_if #(.WIDTH(32)) bus ();

   fast_subtractor_pipe #(.WIDTH(32)) dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int   total = 0;
   int   bad = 0;
   int   rx_count = 0;
   int   ir_drop = 0;
   bit   mon_en = 1'b0;
   bit   track_ir = 1'b0;
   op_t  sb[$];
   op_t  pend[$];
   vec_t vecs[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: results are compared against an arithmetic reference in acceptance order.
   bit          hold_valid = 1'b0;
   logic [31:0] held_diff;
   logic        held_brw, held_ovf;
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.out_valid) begin
            if (hold_valid) begin
               chk("stable_diff", bus.out_diff, held_diff);
               chk("stable_flags", {30'd0, bus.out_borrow, bus.out_overflow}, {30'd0, held_brw, held_ovf});
            end
            if (bus.out_ready) begin
               hold_valid = 1'b0;
               if (sb.size() == 0) begin
                  chk("unexpected_result", 32'd1, 32'd0);
               end else begin
                  op_t         o;
                  logic [31:0] d;
                  o = sb.pop_front();
                  d = o.a - o.b;
                  chk("sb_diff", bus.out_diff, d);
                  chk("sb_borrow", {31'd0, bus.out_borrow}, {31'd0, (o.a < o.b)});
                  chk("sb_ovf", {31'd0, bus.out_overflow},
                      {31'd0, (o.a[31] ^ o.b[31]) & (d[31] ^ o.a[31])});
                  rx_count++;
               end
            end else begin
               hold_valid = 1'b1;
               held_diff  = bus.out_diff;
               held_brw   = bus.out_borrow;
               held_ovf   = bus.out_overflow;
            end
         end else begin
            hold_valid = 1'b0;
         end
         if (bus.in_valid && bus.in_ready) begin
            op_t o;
            o.a = bus.in_a;
            o.b = bus.in_b;
            sb.push_back(o);
         end
      end
   end

   // Called at #1 after a rising edge; presents pend ops until each is accepted.
   task automatic pump(input bit rnd_ready, input int budget, output int cycles);
      bit acc;
      cycles = 0;
      while (pend.size() > 0 && cycles < budget) begin
         bus.in_valid = 1'b1;
         bus.in_a     = pend[0].a;
         bus.in_b     = pend[0].b;
         if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         acc = bus.in_ready;
         if (track_ir && !bus.in_ready) ir_drop++;
         @(posedge clk);
         #1;
         if (acc) void'(pend.pop_front());
         cycles++;
      end
      bus.in_valid = 1'b0;
      chk("pump_timeout", pend.size(), 32'd0);
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (sb.size() == 0) break;
         @(posedge clk);
         #1;
      end
      chk("drain_empty", sb.size(), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      bus.in_a      = v.a;
      bus.in_b      = v.b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_early", idx), {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", idx), {31'd0, bus.out_valid}, 32'd1);
      chk($sformatf("vec%0d_diff", idx), bus.out_diff, v.diff);
      chk($sformatf("vec%0d_borrow", idx), {31'd0, bus.out_borrow}, {31'd0, v.brw});
      chk($sformatf("vec%0d_ovf", idx), {31'd0, bus.out_overflow}, {31'd0, v.ovf});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int rx0;
      op_t o;

      vecs[0] = '{32'h0000_0010, 32'h0000_0003, 32'h0000_000D, 1'b0, 1'b0};
      vecs[1] = '{32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0};
      vecs[2] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
      vecs[3] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
      vecs[4] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1};
      vecs[5] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0};
      vecs[6] = '{32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFE_0001, 1'b0, 1'b0};

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_diff", bus.out_diff, 32'd0);
      chk("rst_flags", {30'd0, bus.out_borrow, bus.out_overflow}, 32'd0);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
      @(posedge clk);
      #1;

      // Back-to-back stream with the sink always ready.
      mon_en = 1'b1;
      bus.out_ready = 1'b1;
      rx0 = rx_count;
      for (int i = 0; i < 100; i++) begin
         o.a = $urandom;
         o.b = $urandom;
         pend.push_back(o);
      end
      track_ir = 1'b1;
      ir_drop  = 0;
      pump(1'b0, 200, cyc);
      track_ir = 1'b0;
      chk("tp_cycles", cyc, 32'd100);
      chk("tp_in_ready_drop", ir_drop, 32'd0);
      drain();
      chk("tp_rx_count", rx_count - rx0, 32'd100);

      // Fill with diffs 5, 6, 7 and stall the sink.
      bus.out_ready = 1'b0;
      rx0 = rx_count;
      pend.push_back('{32'd10, 32'd5});
      pend.push_back('{32'd20, 32'd14});
      pend.push_back('{32'd7, 32'd0});
      pump(1'b0, 10, cyc);
      chk("bp_fill_cycles", cyc, 32'd3);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'd100;
      bus.in_b     = 32'd1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
         chk("bp_diff", bus.out_diff, 32'd5);
         @(posedge clk);
         #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) begin
         o.a = $urandom;
         o.b = $urandom;
         pend.push_back(o);
      end
      pump(1'b1, 500, cyc);
      drain();
      chk("bp_rx_count", rx_count - rx0, 32'd15);
      mon_en = 1'b0;

      // Reset with a full pipe, asserted and released between clock edges.
      bus.out_ready = 1'b0;
      pend.push_back('{32'd50, 32'd1});
      pend.push_back('{32'd60, 32'd2});
      pend.push_back('{32'd70, 32'd3});
      pump(1'b0, 10, cyc);
      chk("rf_full_valid", {31'd0, bus.out_valid}, 32'd1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rf_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rf_diff", bus.out_diff, 32'd0);
      chk("rf_in_ready", {31'd0, bus.in_ready}, 32'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      ir_drop = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) ir_drop++;
      end
      chk("rf_no_stale", ir_drop, 32'd0);
      bus.in_a     = 32'd9;
      bus.in_b     = 32'd4;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("rf_new_early", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      chk("rf_new_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("rf_new_diff", bus.out_diff, 32'd5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fast_subtractor_pipe.md
Name: fast_subtractor_pipe

Overview:
- Pipelined 32-bit unsigned/two's-complement subtractor. It is the inverse-operation companion to the pipelined fast adder.
- Computes out_diff = in_a - in_b as in_a + ~in_b + 1 with carry-lookahead, split across two half-width stages.
- Provides borrow and signed-overflow flags.
- Sits on the datapath behind a valid/ready source and in front of a valid/ready sink. Full throughput with backpressure support.

Parameters:
- WIDTH, 32, operand and difference width; must be even, at least 4.
- HALF, WIDTH/2, split point between the lower-half and upper-half lookahead stages; derived, not overridden.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  in  1  operands on in_a/in_b are valid.
- in_ready  out  1  block can accept operands this cycle.
- in_a  in  WIDTH  minuend.
- in_b  in  WIDTH  subtrahend.
- out_valid  out  1  result on out_* is valid.
- out_ready  in  1  sink accepts the result this cycle.
- out_diff  out  WIDTH  (in_a - in_b) mod 2^WIDTH.
- out_borrow  out  1  1 when in_a < in_b (unsigned).
- out_overflow  out  1  signed overflow: sign(a) != sign(b) and sign(diff) != sign(a).

Behaviour:
- Three register stages, each with its own valid bit (v1, v2, v3).
  - S1: captures in_a and in_b.
  - S2: holds the lower-half difference, the lower carry-out, and the upper operand halves.
  - S3: holds the final diff, borrow and overflow, and drives out_* directly from registers.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Ready chain (combinational, no bubbles):
  - rdy3 = !v3 | out_ready
  - rdy2 = !v2 | rdy3
  - in_ready = !v1 | rdy2
- Stage k loads from stage k-1 when rdy_k is high. Its valid becomes the upstream valid; it clears if upstream is empty. A stage holds its data and valid when rdy_k is low.
- Latency: 3 clock edges from input transfer to out_valid, with no backpressure.
- Throughput: one operation per cycle when out_ready is held high.
- Arithmetic:
  - Lower stage computes a[HALF-1:0] + ~b[HALF-1:0] + 1, giving carry c_lo.
  - Upper stage computes a[W-1:HALF] + ~b[W-1:HALF] + c_lo, giving carry c_hi.
  - out_borrow = !c_hi.
  - out_overflow = (a[W-1] ^ b[W-1]) & (diff[W-1] ^ a[W-1]), using the operands carried with the op.
- Ordering: results leave in acceptance order. No op is dropped or duplicated under any out_ready pattern.
- Backpressure with a full pipe: all of v1..v3 high and out_ready low gives in_ready = 0, and all stages hold.
  - When out_ready rises, all stages advance in the same cycle.
  - in_ready rises combinationally in that same cycle.
- Simultaneous input and output transfer on a full pipe is legal and keeps the pipe full.
- Output stability: while out_valid=1 and out_ready=0, out_diff, out_borrow and out_overflow must not change.
- Reset:
  - On reset=0, immediately and asynchronously, all valid bits go to 0 and all data registers to 0.
  - Resulting outputs: out_valid=0, out_diff=0, out_borrow=0, out_overflow=0. in_ready is 1 once any reset-induced emptiness propagates; it is combinationally 1 while the pipe is empty.
  - Ops in flight at reset are discarded.
  - The first input transfer can occur on the first rising edge after reset deasserts.
- Edge values:
  - a == b gives diff 0, borrow 0.
  - 0 - 1 gives diff all-ones, borrow 1.
  - Most-negative minus 1 sets overflow.

Test Plan:
- Basic: a=0x0000_0010, b=0x0000_0003, out_ready=1 -> after 3 edges out_valid=1, diff=0x0000_000D, borrow=0, overflow=0.
- Borrow and carry across halves:
  - a=0x0001_0000, b=0x0000_0001 -> diff=0x0000_FFFF, borrow=0.
  - a=0, b=1 -> diff=0xFFFF_FFFF, borrow=1, overflow=0.
- Overflow:
  - a=0x8000_0000, b=0x0000_0001 -> diff=0x7FFF_FFFF, overflow=1, borrow=0.
  - a=0x7FFF_FFFF, b=0xFFFF_FFFF -> diff=0x8000_0000, overflow=1, borrow=1.
- Throughput: 100 back-to-back random ops with out_ready=1 -> in_ready stays 1, one result per cycle in order, each matching a-b from the reference model.
- Backpressure:
  - Fill the pipe with ops diffs 5, 6, 7 and hold out_ready=0 for 10 cycles -> in_ready=0, out_diff stays 5 and stable.
  - Toggle out_ready randomly -> 5, 6, 7, then further ops emerge in order with none lost.
- Reset mid-flight: with 3 ops in flight, pull reset low between clock edges -> out_valid=0 and out_diff=0 immediately, no stale result after release, new op a=9, b=4 yields diff=5 exactly 3 edges later.
